// File: rtl/y86_pkg.sv
// Y86-64 shared constants: instruction codes, register IDs, status codes and
// the E pipeline register layout with its bubble value.
package y86_pkg;

  localparam int NREGS = 15;
  localparam int XLEN  = 64;

  typedef logic [3:0] reg_id_t;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

  localparam logic [3:0] AOK = 4'b1000;
  localparam logic [3:0] HLT = 4'b0100;
  localparam logic [3:0] ADR = 4'b0010;
  localparam logic [3:0] INS = 4'b0001;

  typedef struct packed {
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [3:0]      stat;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] vala;
    logic [XLEN-1:0] valb;
    reg_id_t         dst_e;
    reg_id_t         dst_m;
    reg_id_t         src_a;
    reg_id_t         src_b;
  } e_reg_t;

  localparam e_reg_t E_BUBBLE = '{icode: NOP, ifun: 4'h0, stat: AOK,
                                  valc: '0, vala: '0, valb: '0,
                                  dst_e: RNONE, dst_m: RNONE,
                                  src_a: RNONE, src_b: RNONE};

endpackage

// File: rtl/y86_regfile.sv
// 15 x 64-bit register file: two combinational reads, two writes (M port wins
// on a same-register collision), synchronous active-low clear.
module y86_regfile
  import y86_pkg::RNONE;
#(
  parameter int NREGS = 15,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      src_a,
  input  logic [3:0]      src_b,
  output logic [XLEN-1:0] rd_a,
  output logic [XLEN-1:0] rd_b,
  input  logic [3:0]      dst_e,
  input  logic [XLEN-1:0] val_e,
  input  logic [3:0]      dst_m,
  input  logic [XLEN-1:0] val_m
);

  logic [NREGS-1:0][XLEN-1:0] regs;

  // M write issued last so it overrides E on the same register (popq %rsp)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign rd_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode stage + register file feeding the E pipeline register.
// DECODE_FWD_EN adds e_/M_ forwarding; without it only W bypass is present.
module decode_writeback
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      D_icode,
  input  logic [3:0]      D_ifun,
  input  logic [3:0]      D_rA,
  input  logic [3:0]      D_rB,
  input  logic [3:0]      D_stat,
  input  logic [XLEN-1:0] D_valC,
  input  logic [XLEN-1:0] D_valP,
  input  logic [3:0]      e_dstE,
  input  logic [XLEN-1:0] e_valE,
  input  logic [3:0]      M_dstE,
  input  logic [3:0]      M_dstM,
  input  logic [XLEN-1:0] M_valE,
  input  logic [XLEN-1:0] m_valM,
  input  logic [3:0]      W_dstE,
  input  logic [3:0]      W_dstM,
  input  logic [XLEN-1:0] W_valE,
  input  logic [XLEN-1:0] W_valM,
  input  logic            E_bubble,
  output logic [3:0]      d_srcA,
  output logic [3:0]      d_srcB,
  output logic [3:0]      E_icode,
  output logic [3:0]      E_ifun,
  output logic [3:0]      E_stat,
  output logic [XLEN-1:0] E_valC,
  output logic [XLEN-1:0] E_valA,
  output logic [XLEN-1:0] E_valB,
  output logic [3:0]      E_dstE,
  output logic [3:0]      E_dstM,
  output logic [3:0]      E_srcA,
  output logic [3:0]      E_srcB
);

  reg_id_t         d_dst_e, d_dst_m;
  logic [XLEN-1:0] rf_a, rf_b, val_a, val_b;
  e_reg_t          e_q;

  always_comb begin
    d_srcA  = RNONE;
    d_srcB  = RNONE;
    d_dst_e = RNONE;
    d_dst_m = RNONE;
    case (D_icode)
      RRMOVQ, RMMOVQ, OPQ, PUSHQ: d_srcA = D_rA;
      RET, POPQ:                  d_srcA = RSP;
      default: ;
    endcase
    case (D_icode)
      RMMOVQ, MRMOVQ, OPQ:        d_srcB = D_rB;
      CALL, RET, PUSHQ, POPQ:     d_srcB = RSP;
      default: ;
    endcase
    case (D_icode)
      RRMOVQ, IRMOVQ, OPQ:        d_dst_e = D_rB;
      CALL, RET, PUSHQ, POPQ:     d_dst_e = RSP;
      default: ;
    endcase
    case (D_icode)
      MRMOVQ, POPQ:               d_dst_m = D_rA;
      default: ;
    endcase
  end

  y86_regfile #(.NREGS(NREGS), .XLEN(XLEN)) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .rd_a  (rf_a),
    .rd_b  (rf_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );

  // src == RNONE is tested first, so an RNONE destination can never match
  always_comb begin
    val_a = rf_a;
    if (D_icode == JXX || D_icode == CALL) val_a = D_valP;
    else if (d_srcA == RNONE)              val_a = '0;
`ifdef DECODE_FWD_EN
    else if (d_srcA == e_dstE)             val_a = e_valE;
    else if (d_srcA == M_dstM)             val_a = m_valM;
    else if (d_srcA == M_dstE)             val_a = M_valE;
`endif
    else if (d_srcA == W_dstM)             val_a = W_valM;
    else if (d_srcA == W_dstE)             val_a = W_valE;
  end

  always_comb begin
    val_b = rf_b;
    if (d_srcB == RNONE)                   val_b = '0;
`ifdef DECODE_FWD_EN
    else if (d_srcB == e_dstE)             val_b = e_valE;
    else if (d_srcB == M_dstM)             val_b = m_valM;
    else if (d_srcB == M_dstE)             val_b = M_valE;
`endif
    else if (d_srcB == W_dstM)             val_b = W_valM;
    else if (d_srcB == W_dstE)             val_b = W_valE;
  end

`ifndef DECODE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || E_bubble) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= '{icode: D_icode, ifun: D_ifun, stat: D_stat, valc: D_valC,
               vala: val_a, valb: val_b, dst_e: d_dst_e, dst_m: d_dst_m,
               src_a: d_srcA, src_b: d_srcB};
    end
  end

  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_stat  = e_q.stat;
  assign E_valC  = e_q.valc;
  assign E_valA  = e_q.vala;
  assign E_valB  = e_q.valb;
  assign E_dstE  = e_q.dst_e;
  assign E_dstM  = e_q.dst_m;
  assign E_srcA  = e_q.src_a;
  assign E_srcB  = e_q.src_b;

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: driver queues hand-computed E values,
// monitor pops one per clock and compares against the E register outputs.
module tb_decode_writeback;

`ifdef DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [3:0] F = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic        E_bubble;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  always #5 clk = ~clk;

  decode_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_stat(D_stat),
    .D_valC(D_valC), .D_valP(D_valP),
    .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .E_bubble(E_bubble), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  typedef struct {
    string       name;
    logic [3:0]  icode, ifun, stat;
    logic [63:0] valc, vala, valb;
    logic [3:0]  dste, dstm, srca, srcb;
    bit          chk_d;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic exp_t mk(string n, logic [3:0] ic, logic [3:0] fn, logic [3:0] st,
                              logic [63:0] vc, logic [63:0] va, logic [63:0] vb,
                              logic [3:0] de, logic [3:0] dm, logic [3:0] sa, logic [3:0] sb);
    exp_t e;
    e.name = n; e.icode = ic; e.ifun = fn; e.stat = st;
    e.valc = vc; e.vala = va; e.valb = vb;
    e.dste = de; e.dstm = dm; e.srca = sa; e.srcb = sb; e.chk_d = 1'b1;
    return e;
  endfunction

  function automatic exp_t bub(string n);
    exp_t e;
    e = mk(n, 4'h1, 4'h0, 4'b1000, 64'h0, 64'h0, 64'h0, F, F, F, F);
    e.chk_d = 1'b0;
    return e;
  endfunction

  task automatic cmp(string n, string fld, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", n, fld, act, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "icode", {60'h0, E_icode}, {60'h0, e.icode});
        cmp(e.name, "ifun",  {60'h0, E_ifun},  {60'h0, e.ifun});
        cmp(e.name, "stat",  {60'h0, E_stat},  {60'h0, e.stat});
        cmp(e.name, "valC",  E_valC, e.valc);
        cmp(e.name, "valA",  E_valA, e.vala);
        cmp(e.name, "valB",  E_valB, e.valb);
        cmp(e.name, "dstE",  {60'h0, E_dstE},  {60'h0, e.dste});
        cmp(e.name, "dstM",  {60'h0, E_dstM},  {60'h0, e.dstm});
        cmp(e.name, "srcA",  {60'h0, E_srcA},  {60'h0, e.srca});
        cmp(e.name, "srcB",  {60'h0, E_srcB},  {60'h0, e.srcb});
        if (e.chk_d) begin
          cmp(e.name, "d_srcA", {60'h0, d_srcA}, {60'h0, e.srca});
          cmp(e.name, "d_srcB", {60'h0, d_srcB}, {60'h0, e.srcb});
        end
      end
    end
  end

  task automatic idle();
    D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F; D_stat = 4'b1000;
    D_valC = 64'h0; D_valP = 64'h0;
    e_dstE = F; e_valE = 64'h0; M_dstE = F; M_dstM = F; M_valE = 64'h0; m_valM = 64'h0;
    W_dstE = F; W_dstM = F; W_valE = 64'h0; W_valM = 64'h0;
    E_bubble = 1'b0;
  endtask

  task automatic setd(logic [3:0] ic, logic [3:0] fn, logic [3:0] ra, logic [3:0] rb,
                      logic [63:0] vc, logic [63:0] vp);
    D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin : driver
    rst_n = 1'b0;
    idle();
    // reset must override both a pending W write and a valid D
    for (int i = 0; i < 2; i++) begin
      cyc();
      setd(4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h0);
      W_dstE = 4'h2; W_valE = 64'hDEAD;
      q.push_back(bub("reset"));
    end

    for (int r = 0; r < 15; r++) begin
      cyc();
      rst_n = 1'b1;
      setd(4'h6, 4'h0, r[3:0], r[3:0], 64'h0, 64'h0);
      q.push_back(mk("rd_zero", 4'h6, 4'h0, 4'h8, 64'h0, 64'h0, 64'h0, r[3:0], F, r[3:0], r[3:0]));
    end

    cyc(); setd(4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h0); W_dstE = 4'h2; W_valE = 64'h5;
    q.push_back(mk("wr_through", 4'h6, 4'h1, 4'h8, 64'h0, 64'h5, 64'h0, 4'h3, F, 4'h2, 4'h3));
    cyc(); setd(4'h6, 4'h0, 4'h3, 4'h2, 64'h0, 64'h0);
    q.push_back(mk("rf_reg2", 4'h6, 4'h0, 4'h8, 64'h0, 64'h0, 64'h5, 4'h2, F, 4'h3, 4'h2));

    cyc(); setd(4'h6, 4'h0, 4'h3, 4'h0, 64'h0, 64'h0);
    e_dstE = 4'h3; e_valE = 64'h11; M_dstE = 4'h3; M_valE = 64'h22; W_dstE = 4'h3; W_valE = 64'h33;
    q.push_back(mk("prio_e", 4'h6, 4'h0, 4'h8, 64'h0, FWD ? 64'h11 : 64'h33, 64'h0, 4'h0, F, 4'h3, 4'h0));
    cyc(); setd(4'h6, 4'h0, 4'h3, 4'h0, 64'h0, 64'h0);
    M_dstE = 4'h3; M_valE = 64'h22; W_dstE = 4'h3; W_valE = 64'h33;
    q.push_back(mk("prio_m", 4'h6, 4'h0, 4'h8, 64'h0, FWD ? 64'h22 : 64'h33, 64'h0, 4'h0, F, 4'h3, 4'h0));
    cyc(); setd(4'h6, 4'h0, 4'h3, 4'h0, 64'h0, 64'h0);
    M_dstM = 4'h3; m_valM = 64'h44; M_dstE = 4'h3; M_valE = 64'h22;
    q.push_back(mk("prio_mm", 4'h6, 4'h0, 4'h8, 64'h0, FWD ? 64'h44 : 64'h33, 64'h0, 4'h0, F, 4'h3, 4'h0));

    cyc(); W_dstE = 4'h4; W_valE = 64'h108; W_dstM = 4'h4; W_valM = 64'h55;
    q.push_back(mk("dual_nop", 4'h1, 4'h0, 4'h8, 64'h0, 64'h0, 64'h0, F, F, F, F));
    cyc(); setd(4'h9, 4'h0, F, F, 64'h0, 64'h0);
    q.push_back(mk("ret_dual", 4'h9, 4'h0, 4'h8, 64'h0, 64'h55, 64'h55, 4'h4, F, 4'h4, 4'h4));

    cyc(); W_dstM = 4'h4; W_valM = 64'h200;
    q.push_back(mk("set_rsp", 4'h1, 4'h0, 4'h8, 64'h0, 64'h0, 64'h0, F, F, F, F));
    cyc(); setd(4'h8, 4'h0, F, F, 64'h123, 64'h40);
    q.push_back(mk("call", 4'h8, 4'h0, 4'h8, 64'h123, 64'h40, 64'h200, 4'h4, F, F, 4'h4));
    cyc(); setd(4'h7, 4'h3, F, F, 64'h80, 64'h99);
    q.push_back(mk("jxx", 4'h7, 4'h3, 4'h8, 64'h80, 64'h99, 64'h0, F, F, F, F));

    cyc(); setd(4'h3, 4'h0, F, 4'h1, 64'h7, 64'h0); E_bubble = 1'b1;
    q.push_back(bub("bubble"));
    cyc(); setd(4'h3, 4'h0, F, 4'h1, 64'h7, 64'h0);
    q.push_back(mk("irmovq", 4'h3, 4'h0, 4'h8, 64'h7, 64'h0, 64'h0, 4'h1, F, F, F));

    cyc(); setd(4'h5, 4'h0, 4'h7, 4'h3, 64'h10, 64'h0);
    q.push_back(mk("mrmovq", 4'h5, 4'h0, 4'h8, 64'h10, 64'h0, 64'h33, F, 4'h7, F, 4'h3));
    cyc(); setd(4'hB, 4'h0, 4'h6, F, 64'h0, 64'h0);
    q.push_back(mk("popq", 4'hB, 4'h0, 4'h8, 64'h0, 64'h200, 64'h200, 4'h4, 4'h6, 4'h4, 4'h4));
    cyc(); setd(4'h9, 4'h0, F, F, 64'h0, 64'h0);
    W_dstE = 4'h4; W_valE = 64'h1; W_dstM = 4'h4; W_valM = 64'h2;
    q.push_back(mk("ret_bypass", 4'h9, 4'h0, 4'h8, 64'h0, 64'h2, 64'h2, 4'h4, F, 4'h4, 4'h4));
    cyc(); setd(4'h9, 4'h0, F, F, 64'h0, 64'h0);
    q.push_back(mk("ret_after", 4'h9, 4'h0, 4'h8, 64'h0, 64'h2, 64'h2, 4'h4, F, 4'h4, 4'h4));

    cyc(); setd(4'h0, 4'h0, F, F, 64'h0, 64'h0); D_stat = 4'b0100;
    q.push_back(mk("halt_stat", 4'h0, 4'h0, 4'h4, 64'h0, 64'h0, 64'h0, F, F, F, F));

    cyc(); rst_n = 1'b0; setd(4'h6, 4'h0, 4'h4, 4'h4, 64'h0, 64'h0);
    q.push_back(bub("reset2"));
    cyc(); rst_n = 1'b1; setd(4'h9, 4'h0, F, F, 64'h0, 64'h0);
    q.push_back(mk("ret_cleared", 4'h9, 4'h0, 4'h8, 64'h0, 64'h0, 64'h0, 4'h4, F, 4'h4, 4'h4));

    cyc();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- Y86-64 pipeline decode stage plus register file; it consumes the D pipeline register produced by fetch.
- Derives source and destination register IDs from D_icode, D_rA and D_rB.
- Reads the 15-entry, 64-bit register file and selects valA/valB through the forwarding network.
- Registers results into the E pipeline register. The register file is written from the W stage (writeback).

Parameters:
- NREGS, 15, number of architectural registers (IDs 0..14; ID 4'hF = none).
- XLEN, 64, data width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- D_icode, D_ifun, D_rA, D_rB, D_stat  in  4 each  D-register fields.
- D_valC, D_valP  in  64 each  D-register constants.
- e_dstE  in  4, e_valE  in  64  execute-stage result.
- M_dstE, M_dstM  in  4 each, M_valE  in  64, m_valM  in  64  memory-stage results.
- W_dstE, W_dstM  in  4 each, W_valE, W_valM  in  64 each  writeback ports.
- E_bubble  in  1  insert nop into E.
- d_srcA, d_srcB  out  4 each  combinational source IDs, for the hazard unit.
- E_icode, E_ifun, E_stat  out  4 each  registered.
- E_valC, E_valA, E_valB  out  64 each  registered.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered.

Behaviour:
- Reset: rst_n low at posedge clears all 15 registers to 0. E is loaded with the bubble value:
  - icode 1, ifun 0, stat 4'b1000;
  - valC/valA/valB 0;
  - dstE/dstM/srcA/srcB 4'hF.
- Reset overrides E_bubble and any W write in the same cycle.
- Source and destination decode (combinational; RSP = 4):
  - d_srcA: rA for icode 2, 4, 6, 10; RSP for 9, 11; else F.
  - d_srcB: rB for 4, 5, 6; RSP for 8, 9, 10, 11; else F.
  - d_dstE: rB for 2, 3, 6; RSP for 8, 9, 10, 11; else F.
  - d_dstM: rA for 5, 11; else F.
- valA selection, first match wins:
  1. icode 7 or 8 → D_valP.
  2. srcA == F → 0.
  3. srcA == e_dstE → e_valE.
  4. srcA == M_dstM → m_valM.
  5. srcA == M_dstE → M_valE.
  6. srcA == W_dstM → W_valM.
  7. srcA == W_dstE → W_valE.
  8. Otherwise the register file value.
- valB selection: same priority chain without step 1.
- A forwarding source with dst == F never matches.
- Register file write at posedge:
  - W_dstE != F writes W_valE; W_dstM != F writes W_valM.
  - If both target the same register, W_valM wins (popq %rsp yields the popped value).
- E update at posedge when not in reset:
  - E_bubble = 1 → bubble value.
  - Otherwise E takes {D_icode, D_ifun, D_stat, D_valC, valA, valB, d_dstE, d_dstM, d_srcA, d_srcB}.
- Latency: one cycle from D to E.
- No stall input: E always advances.
- D_stat passes through unchanged; the decode stage raises no exceptions.

Optional Feature:
- Macro DECODE_FWD_EN.
- Defined: full priority chain above.
- Undefined: steps 3–5 are removed.
  - valA/valB come from the register file with write-through bypass only, equivalent to steps 6–7.
  - The hazard unit must stall on any e_/M_ dependency.
- d_srcA/d_srcB are present in both builds.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT..POPQ);
  - register IDs RSP = 4 and RNONE = 4'hF;
  - stat codes AOK = 4'b1000, HLT = 4'b0100, ADR = 4'b0010, INS = 4'b0001;
  - the E bubble constant fields.
- One sub-module, y86_regfile:
  - two combinational read ports, two synchronous write ports with M-priority;
  - synchronous active-low clear.

Test Plan:
- Reset: rst_n = 0 for 2 cycles → E_icode = 1, E_dstE = F, E_stat = 4'b1000; every register reads 0.
- Write-through: W_dstE = 2, W_valE = 5, with D OPq (icode 6, rA = 2, rB = 3) in the same cycle → E_valA = 5 next cycle; register 2 reads 5 afterwards.
- Priority (DECODE_FWD_EN): srcA = 3, e_dstE = 3/0x11, M_dstE = 3/0x22, W_dstE = 3/0x33 → E_valA = 0x11. Drop e_dstE → 0x22.
- Dual write: W_dstE = 4/0x108 and W_dstM = 4/0x55 in one cycle → later ret decodes E_valA = E_valB = 0x55.
- Call: D_icode = 8, D_valP = 0x40, e_dstE = F, register 4 = 0x200 → E_valA = 0x40, E_valB = 0x200, E_dstE = 4, E_srcB = 4.
- Bubble: E_bubble = 1 with D irmovq (icode 3, rB = 1, valC = 7) → E_icode = 1, E_dstE = F, E_valC = 0. Deasserting E_bubble → E_icode = 3, E_dstE = 1, E_valC = 7.
